// File: rtl/wreq_wdat_queue_subo_pkg.sv
// rtl/wreq_wdat_queue_subo_pkg.sv - shared widths, depth and output-stage state type
// Holds the default DEPTH/AW/DW for the write-path queue. The AXI subordinate
// address width lives here so the upstream channel logic and this queue agree.
package wreq_wdat_queue_subo_pkg;

   localparam int WQ_AXI_S_AW = 32;
   localparam int WQ_DEPTH    = 4;
   localparam int WQ_AW       = WQ_AXI_S_AW;
   localparam int WQ_DW       = 128;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_HOLD  = 1'b1
   } wq_ostate_e;

endpackage

// File: rtl/wreq_wdat_queue_subo_sync_fifo.sv
// rtl/wreq_wdat_queue_subo_sync_fifo.sv - in-order synchronous FIFO with occupancy count
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   push, din    write one entry; ignored when full unless pop is also asserted
//   pop, dout    remove the head entry; dout always shows the head
//   empty, full  occupancy flags
//   count        entries held, clog2(DEPTH)+1 bits
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wptr;
   logic [PW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   // A push into a full FIFO is only accepted when the head leaves in the same cycle.
   assign w_pop  = pop && (r_count != '0);
   assign w_push = push && ((r_count != FULL_CNT) || w_pop);

   assign dout  = r_mem[r_rptr];
   assign empty = (r_count == '0);
   assign full  = (r_count == FULL_CNT);
   assign count = r_count;

   // Storage carries no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= din;
      end
   end

   // Pointers are PW bits wide, so they wrap modulo DEPTH (power of two).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/wreq_wdat_queue_subo.sv
// rtl/wreq_wdat_queue_subo.sv - pairs queued write addresses and lines into memory write commands
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   wreqc_s_valid, wreqc_s_addr    address push into the address FIFO
//   wqfull_1                       address FIFO holds >= DEPTH-1 entries
//   wdat_s_valid, wdat_s_data      line push into the data FIFO
//   sqfull_1                       data FIFO holds >= DEPTH-1 entries
//   mem_wvalid, mem_wready         memory write command handshake
//   mem_waddr, mem_wdata           command address and line, stable while stalled
//   q_ovf                          sticky: a push hit a full FIFO with no pop
module wreq_wdat_queue_subo
   import wreq_wdat_queue_subo_pkg::*;
#(
   parameter int DEPTH = WQ_DEPTH,
   parameter int AW    = WQ_AW,
   parameter int DW    = WQ_DW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wreqc_s_valid,
   input  logic [AW-1:0] wreqc_s_addr,
   output logic          wqfull_1,
   input  logic          wdat_s_valid,
   input  logic [DW-1:0] wdat_s_data,
   output logic          sqfull_1,
   output logic          mem_wvalid,
   input  logic          mem_wready,
   output logic [AW-1:0] mem_waddr,
   output logic [DW-1:0] mem_wdata,
   output logic          q_ovf
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] ALMOST_CNT = CW'(DEPTH - 1);

   logic [AW-1:0] w_a_dout;
   logic          w_a_empty;
   logic          w_a_full;
   logic [CW-1:0] w_a_count;
   logic [DW-1:0] w_d_dout;
   logic          w_d_empty;
   logic          w_d_full;
   logic [CW-1:0] w_d_count;
   logic          w_load;
   logic          w_drop;

   wq_ostate_e    r_state;
   logic [AW-1:0] r_waddr;
   logic [DW-1:0] r_wdata;
   logic          r_ovf;

   sync_fifo #(.WIDTH(AW), .DEPTH(DEPTH)) u_afifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (wreqc_s_valid),
      .din   (wreqc_s_addr),
      .pop   (w_load),
      .dout  (w_a_dout),
      .empty (w_a_empty),
      .full  (w_a_full),
      .count (w_a_count)
   );

   sync_fifo #(.WIDTH(DW), .DEPTH(DEPTH)) u_dfifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (wdat_s_valid),
      .din   (wdat_s_data),
      .pop   (w_load),
      .dout  (w_d_dout),
      .empty (w_d_empty),
      .full  (w_d_full),
      .count (w_d_count)
   );

   // Both heads pop together, so the k-th address always meets the k-th line.
   // The output register refills in the same cycle the current command is taken.
   assign w_load = !w_a_empty && !w_d_empty && ((r_state == ST_EMPTY) || mem_wready);

   // Both FIFOs pop only on load, so a push into a full FIFO without load is lost.
   assign w_drop = (wreqc_s_valid && w_a_full && !w_load) ||
                   (wdat_s_valid  && w_d_full && !w_load);

   assign wqfull_1   = (w_a_count >= ALMOST_CNT);
   assign sqfull_1   = (w_d_count >= ALMOST_CNT);
   assign mem_wvalid = (r_state == ST_HOLD);
   assign mem_waddr  = r_waddr;
   assign mem_wdata  = r_wdata;
   assign q_ovf      = r_ovf;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_EMPTY;
         r_waddr <= '0;
         r_wdata <= '0;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_load) begin
                  r_state <= ST_HOLD;
                  r_waddr <= w_a_dout;
                  r_wdata <= w_d_dout;
               end
            end
            ST_HOLD: begin
               if (w_load) begin
                  r_waddr <= w_a_dout;
                  r_wdata <= w_d_dout;
               end else if (mem_wready) begin
                  r_state <= ST_EMPTY;
               end
            end
            default: r_state <= ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (w_drop) begin
         r_ovf <= 1'b1;
      end
   end

endmodule
